// File: rtl/arith_range_update.sv
// arith_range_update: range-update stage of the AV1 arithmetic encoder.
// One symbol is handled per request. The block latches the request, drives
// the v-term ROM address, and combines the ROM word with the scaled CDF bounds
// to get the low increment and the new range. It then normalises the range so
// that bit 15 is set. The range is held internally between symbols.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   frame_init         reload range to 0x8000 (only while idle)
//   in_valid/in_ready  symbol request handshake
//   bool_mode/bool_val binary symbol select and its bit value
//   fl, fh             inverse-CDF bounds (fh = probability in bool mode)
//   symbol, nsyms_m1   symbol index s and N = nsyms-1
//   lut_addr/lut_q     v-term ROM address and same-cycle data (4*(N-s))
//   out_valid/out_ready result handshake
//   low_inc, rng_out, shift  increment to low, normalised range, shift d
module arith_range_update #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_init,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  bool_mode,
  input  logic                  bool_val,
  input  logic [DATA_WIDTH-1:0] fl,
  input  logic [DATA_WIDTH-1:0] fh,
  input  logic [3:0]            symbol,
  input  logic [3:0]            nsyms_m1,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] low_inc,
  output logic [DATA_WIDTH-1:0] rng_out,
  output logic [3:0]            shift
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [15:0] RANGE_INIT = 16'h8000;

  state_t      state_q, state_d;
  logic [15:0] range_q, range_d;
  logic        bool_mode_q, bool_mode_d;
  logic        bool_val_q, bool_val_d;
  logic [15:0] fl_q, fl_d;
  logic [15:0] fh_q, fh_d;
  logic [3:0]  symbol_q, symbol_d;
  logic [3:0]  nsyms_q, nsyms_d;
  logic [15:0] low_inc_q, low_inc_d;
  logic [15:0] rng_q, rng_d;
  logic [3:0]  shift_q, shift_d;

  logic [17:0] prod_l, prod_h, u_s, v_s, vb_s;
  logic [15:0] calc_low, rn, norm_rng;
  logic [3:0]  norm_shift;
  logic        unused_bits;

  // Only the top 10 bits of each CDF bound enter the products.
  assign unused_bits = ^{fl_q[5:0], fh_q[5:0]};

  // Left shift that brings the most significant set bit to bit 15 (15 for zero).
  function automatic logic [3:0] lead_shift(input logic [15:0] x);
    logic [3:0] s;
    s = 4'd15;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) s = 4'(15 - i);
      else      s = s;
    end
    return s;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      range_q     <= RANGE_INIT;
      bool_mode_q <= 1'b0;
      bool_val_q  <= 1'b0;
      fl_q        <= 16'd0;
      fh_q        <= 16'd0;
      symbol_q    <= 4'd0;
      nsyms_q     <= 4'd0;
      low_inc_q   <= 16'd0;
      rng_q       <= 16'd0;
      shift_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      range_q     <= range_d;
      bool_mode_q <= bool_mode_d;
      bool_val_q  <= bool_val_d;
      fl_q        <= fl_d;
      fh_q        <= fh_d;
      symbol_q    <= symbol_d;
      nsyms_q     <= nsyms_d;
      low_inc_q   <= low_inc_d;
      rng_q       <= rng_d;
      shift_q     <= shift_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) state_d = S_CALC;
        else                      state_d = S_IDLE;
      end
      S_CALC: state_d = S_OUT;
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and ROM address outputs.
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !frame_init;
    out_valid = (state_q == S_OUT);
    if (bool_mode_q) lut_addr = {ADDR_WIDTH{1'b0}};
    else             lut_addr = {nsyms_q, symbol_q};
  end

  // Scaled-probability arithmetic and range normalisation.
  always_comb begin
    prod_l = {10'd0, range_q[15:8]} * {8'd0, fl_q[15:6]};
    prod_h = {10'd0, range_q[15:8]} * {8'd0, fh_q[15:6]};
    u_s    = {1'b0, prod_l[17:1]} + {2'b00, lut_q} + 18'd4;
    v_s    = {1'b0, prod_h[17:1]} + {2'b00, lut_q};
    vb_s   = {1'b0, prod_h[17:1]} + 18'd4;
    // All partial results are below R, so 16-bit wrap-around subtraction is exact.
    if (bool_mode_q) begin
      if (bool_val_q) begin
        calc_low = range_q - vb_s[15:0];
        rn       = vb_s[15:0];
      end else begin
        calc_low = 16'd0;
        rn       = range_q - vb_s[15:0];
      end
    end else if (!fl_q[15]) begin
      calc_low = range_q - u_s[15:0];
      rn       = u_s[15:0] - v_s[15:0];
    end else begin
      calc_low = 16'd0;
      rn       = range_q - v_s[15:0];
    end
    norm_shift = lead_shift(rn);
    norm_rng   = rn << norm_shift;
  end

  // Request capture, range update and result registers.
  always_comb begin
    range_d     = range_q;
    bool_mode_d = bool_mode_q;
    bool_val_d  = bool_val_q;
    fl_d        = fl_q;
    fh_d        = fh_q;
    symbol_d    = symbol_q;
    nsyms_d     = nsyms_q;
    low_inc_d   = low_inc_q;
    rng_d       = rng_q;
    shift_d     = shift_q;
    case (state_q)
      S_IDLE: begin
        // frame_init also blocks in_ready, so it takes precedence over a request.
        if (frame_init) begin
          range_d = RANGE_INIT;
        end else if (in_valid) begin
          bool_mode_d = bool_mode;
          bool_val_d  = bool_val;
          fl_d        = fl;
          fh_d        = fh;
          symbol_d    = symbol;
          nsyms_d     = nsyms_m1;
        end else begin
          range_d = range_q;
        end
      end
      S_CALC: begin
        low_inc_d = calc_low;
        rng_d     = norm_rng;
        shift_d   = norm_shift;
        range_d   = norm_rng;
      end
      S_OUT:   range_d = range_q;
      default: range_d = range_q;
    endcase
  end

  assign low_inc = low_inc_q;
  assign rng_out = rng_q;
  assign shift   = shift_q;

endmodule

// arith_range_update_chk: a zero pre-normalisation range shows up as a
// result with rng_out[15] clear or a shift above 13.
// Ports: clk, reset, out_valid, rng_out, shift observed from the stage.
module arith_range_update_chk (
  input logic        clk,
  input logic        reset,
  input logic        out_valid,
  input logic [15:0] rng_out,
  input logic [3:0]  shift
);
  // A valid result must be normalised with a legal shift.
  always @(posedge clk) begin
    if (!reset && out_valid) begin
      assert (rng_out[15] && (shift <= 4'd13))
        else $error("range not normalised: rng_out=%h shift=%0d", rng_out, shift);
    end
  end
endmodule
